pipe_stall_ctrl: RTL and testbench

Central pipeline control for the 5-stage MIPS core. It merges per-stage stall requests (ID load-use, EX multiply/divide, MEM SRAM wait) into the shared `stall` bus consumed by PC/IF/ID/EX/MEM/WB. It sequences multi-cycle MDU operations with an internal cycle counter, and issues pipeline flushes carrying the redirect PC on exceptions and `eret`. It sits beside the stage chain and is the only driver of `stall` and `flush`.

---
 rtl/pipe_stall_ctrl_pkg.sv | 26 ++
 rtl/pipe_stall_ctrl_counter.sv | 29 ++
 rtl/pipe_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared stall bus type, masks and control state encodings
package pipe_stall_ctrl_pkg;

    typedef logic [5:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. Each mask freezes its stage and all upstream.
    localparam stall_bus_t STALL_NONE = {6{NO_STOP}};
    localparam stall_bus_t STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
    localparam stall_bus_t STALL_MDU  = {{2{NO_STOP}}, {4{STOP}}};
    localparam stall_bus_t STALL_MEM  = {NO_STOP, {5{STOP}}};

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MDU_WAIT   = 2'd1,
        ST_MDU_HOLD   = 2'd2,
        ST_FLUSH_PEND = 2'd3
    } ctrl_state_t;

    function automatic stall_bus_t merge_stall(input logic id_req, input logic mdu_req, input logic mem_req);
        return ({6{id_req}} & STALL_ID) | ({6{mdu_req}} & STALL_MDU) | ({6{mem_req}} & STALL_MEM);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_counter.sv
// rtl/pipe_stall_ctrl_counter.sv - MDU cycle counter with load, decrement, clear and zero flag
module mdu_cycle_counter #(
    parameter int WIDTH    = 5,
    parameter int LOAD_VAL = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= WIDTH'(LOAD_VAL);
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - merges stage stall requests, sequences MDU ops and issues redirect flushes
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id,
    input  logic        mdu_start,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic        mdu_abort
);

    localparam int CNT_W = $clog2(MDU_CYCLES);

    ctrl_state_t      state;
    logic [31:0]      pc_latched;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic             in_mdu;
    logic             pend;
    logic             mdu_active;
    logic             mdu_release;
    logic             flush_go;

    assign in_mdu      = (state == ST_MDU_WAIT) || (state == ST_MDU_HOLD);
    assign pend        = (state == ST_FLUSH_PEND);
    assign mdu_release = (((state == ST_MDU_WAIT) && cnt_zero) || (state == ST_MDU_HOLD)) && !stallreq_mem;
    assign flush_go    = (flush_req || pend) && !stallreq_mem;
    assign cnt_load    = (state == ST_RUN) && mdu_start && !stallreq_mem && !flush_req;

    mdu_cycle_counter #(
        .WIDTH    (CNT_W),
        .LOAD_VAL (MDU_CYCLES - 1)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .dec   (state == ST_MDU_WAIT),
        .clr   (flush_req),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    always_comb begin
        mdu_active = 1'b0;
        case (state)
            ST_RUN:      mdu_active = mdu_start && !stallreq_mem;
            ST_MDU_WAIT: mdu_active = !(cnt_zero && !stallreq_mem);
            ST_MDU_HOLD: mdu_active = stallreq_mem;
            default:     mdu_active = 1'b0;
        endcase
    end

    // A pending or held-off flush owns the bus: only the MEM mask survives until the redirect fires.
    always_comb begin
        if (!rst_n || flush_go) begin
            stall = STALL_NONE;
        end else if (flush_req || pend) begin
            stall = STALL_MEM;
        end else begin
            stall = merge_stall(stallreq_id, mdu_active, stallreq_mem);
        end
    end

    assign flush     = rst_n && flush_go;
    assign new_pc    = flush ? (flush_req ? flush_pc : pc_latched) : 32'h0;
    assign mdu_busy  = rst_n && in_mdu;
    assign mdu_done  = rst_n && mdu_release && !flush_req;
    assign mdu_abort = rst_n && flush_req && in_mdu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            pc_latched <= 32'h0;
        end else if (flush_req) begin
            if (stallreq_mem) begin
                state      <= ST_FLUSH_PEND;
                pc_latched <= flush_pc;
            end else begin
                state <= ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (mdu_start && !stallreq_mem) begin
                        state <= ST_MDU_WAIT;
                    end
                end
                ST_MDU_WAIT: begin
                    if (cnt_zero) begin
                        state <= stallreq_mem ? ST_MDU_HOLD : ST_RUN;
                    end
                end
                ST_MDU_HOLD: begin
                    if (!stallreq_mem) begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH_PEND: begin
                    if (!stallreq_mem) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    localparam logic [5:0] M_ID  = 6'b000111;
    localparam logic [5:0] M_MDU = 6'b001111;
    localparam logic [5:0] M_MEM = 6'b011111;

    typedef logic [41:0] obs_t;

    logic        clk;
    logic        rst_n;
    logic        stallreq_id;
    logic        mdu_start;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mdu_busy;
    logic        mdu_done;
    logic        mdu_abort;

    obs_t exp_q[$];
    obs_t e;
    obs_t obs_now;
    int   total;
    int   bad;

    pipe_stall_ctrl #(.MDU_CYCLES(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_id  (stallreq_id),
        .mdu_start    (mdu_start),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done),
        .mdu_abort    (mdu_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_now = {stall, flush, new_pc, mdu_done, mdu_abort, mdu_busy};

    function automatic obs_t mk(logic [5:0] s, logic f, logic [31:0] pc, logic d, logic a, logic b);
        return {s, f, pc, d, a, b};
    endfunction

    task automatic drive(logic id, logic ms, logic mem, logic fr, logic [31:0] pc);
        stallreq_id  = id;
        mdu_start    = ms;
        stallreq_mem = mem;
        flush_req    = fr;
        flush_pc     = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
            exp_q.push_back(mk(6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(mk(6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs_now !== e) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs_now, e);
        end
    endtask

    task automatic test_id_stall();
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            drive(i == 1, 1'b0, 1'b0, 1'b0, 32'h0);
            exp_q.push_back(mk(i == 1 ? M_ID : 6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL id_stall cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    task automatic test_mdu();
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            drive(1'b0, i <= 33, 1'b0, 1'b0, 32'h0);
            exp_q.push_back(mk(i <= 32 ? M_MDU : 6'b0, 1'b0, 32'h0, i == 33, 1'b0, i >= 2 && i <= 33));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL mdu cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    task automatic test_mdu_mem();
        logic mem;
        logic [5:0] s;
        for (int i = 1; i <= 42; i++) begin
            mem = (i >= 30 && i <= 40);
            s = mem ? M_MEM : (i <= 29 ? M_MDU : 6'b0);
            @(negedge clk);
            drive(1'b0, i <= 41, mem, 1'b0, 32'h0);
            exp_q.push_back(mk(s, 1'b0, 32'h0, i == 41, 1'b0, i >= 2 && i <= 41));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL mdu_mem cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    task automatic test_flush_mdu();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            drive(1'b0, i <= 5, 1'b0, i == 5, i == 5 ? 32'hBFC00380 : 32'h0);
            if (i < 5)
                exp_q.push_back(mk(M_MDU, 1'b0, 32'h0, 1'b0, 1'b0, i >= 2));
            else if (i == 5)
                exp_q.push_back(mk(6'b0, 1'b1, 32'hBFC00380, 1'b0, 1'b1, 1'b1));
            else
                exp_q.push_back(mk(6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL flush_mdu cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    task automatic test_flush_pend();
        logic [31:0] pc;
        for (int i = 1; i <= 7; i++) begin
            pc = (i == 1) ? 32'h80000180 : (i == 2 ? 32'hBFC00200 : 32'h0);
            @(negedge clk);
            drive(i <= 6, 1'b0, i <= 4, i <= 2, pc);
            if (i <= 4)
                exp_q.push_back(mk(M_MEM, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            else if (i == 5)
                exp_q.push_back(mk(6'b0, 1'b1, 32'hBFC00200, 1'b0, 1'b0, 1'b0));
            else if (i == 6)
                exp_q.push_back(mk(M_ID, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            else
                exp_q.push_back(mk(6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL flush_pend cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    task automatic test_reset_mid_mdu();
        for (int i = 1; i <= 52; i++) begin
            @(negedge clk);
            if (i == 11) rst_n = 1'b0;
            if (i == 13) rst_n = 1'b1;
            drive(1'b0, i <= 12, 1'b0, 1'b0, 32'h0);
            if (i <= 10)
                exp_q.push_back(mk(M_MDU, 1'b0, 32'h0, 1'b0, 1'b0, i >= 2));
            else
                exp_q.push_back(mk(6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL reset_mid_mdu cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            case (i)
                1: drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
                2, 3: drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
                4: drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
                5: drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h80000180);
                7: drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400000);
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            endcase
            case (i)
                1: exp_q.push_back(mk(M_MEM, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
                2: exp_q.push_back(mk(M_MDU, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
                3, 4: exp_q.push_back(mk(M_MDU, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
                5: exp_q.push_back(mk(6'b0, 1'b1, 32'h80000180, 1'b0, 1'b1, 1'b1));
                7: exp_q.push_back(mk(6'b0, 1'b1, 32'h00400000, 1'b0, 1'b0, 1'b0));
                default: exp_q.push_back(mk(6'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
            endcase
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs_now !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, obs_now, e);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_id_stall();
        test_mdu();
        test_mdu_mem();
        test_flush_mdu();
        test_flush_pend();
        test_reset_mid_mdu();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
